// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared types and constants for the run controller.
//   ctrl_state_e : control states of the run/halt/step controller
//   PH_*         : bit indices into the one-hot sequencer phase vector
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    CS_RUN       = 2'd0,
    CS_HALT_PEND = 2'd1,
    CS_HALTED    = 2'd2,
    CS_STEP      = 2'd3
  } ctrl_state_e;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_SLEEP  = 3;

endpackage

// File: rtl/run_ctrl_cnt.sv
// run_ctrl_cnt -- retired-instruction counter with optional breakpoint compare.
//   clk, rst     : clock, async active-low reset
//   exec         : sequencer is in its execute phase this cycle
//   retired      : count of execute cycles, wraps modulo 2^CNT_W
//   bkpt_val     : breakpoint count, 0 disables    (RUN_CTRL_BKPT_EN only)
//   bkpt_match   : this execute would retire instruction number bkpt_val
//                  (RUN_CTRL_BKPT_EN only; combinational, not gated by exec)
module run_ctrl_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
`ifdef RUN_CTRL_BKPT_EN
  input  logic [CNT_W-1:0] bkpt_val,
  output logic             bkpt_match,
`endif
  output logic [CNT_W-1:0] retired
);

  logic [CNT_W-1:0] retired_q, retired_d, retired_inc;

  assign retired_inc = retired_q + CNT_W'(1);

  always_comb begin
    retired_d = retired_q;
    if (exec) retired_d = retired_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired_q <= '0;
    else      retired_q <= retired_d;
  end

  assign retired = retired_q;

`ifdef RUN_CTRL_BKPT_EN
  // Compare against the post-increment value so the hit is known during the
  // execute cycle itself, early enough to drop run in that same cycle.
  assign bkpt_match = (bkpt_val != '0) && (retired_inc == bkpt_val);
`endif

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl -- run/halt/single-step controller for an instruction sequencer.
// Optional feature macro: RUN_CTRL_BKPT_EN (adds retired-count breakpoint).
//   clk, rst     : clock, async active-low reset
//   halt_req     : one-cycle halt request
//   resume_req   : one-cycle resume request
//   step_req     : one-cycle single-step request
//   state        : one-hot sequencer phase (fetch, decode, execute, sleep)
//   run          : combinational run enable back to the sequencer
//   halted       : registered, high while parked in HALTED
//   step_done    : registered one-cycle pulse when a step completes
//   retired      : count of execute cycles
//   bkpt_val     : breakpoint retired count, 0 disables (RUN_CTRL_BKPT_EN)
//   bkpt_hit     : registered pulse on first HALTED cycle after a breakpoint
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic [3:0]       state,
`ifdef RUN_CTRL_BKPT_EN
  input  logic [CNT_W-1:0] bkpt_val,
  output logic             bkpt_hit,
`endif
  output logic             run,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] retired
);

  localparam ctrl_state_e RST_STATE = RESET_HALTED ? CS_HALT_PEND : CS_RUN;

  ctrl_state_e ctrl_q, ctrl_d;
  logic        halted_q, halted_d;
  logic        step_done_q, step_done_d;
  logic        exec;
  logic        bkpt_match;
  logic        bkpt_fire;

  // Only the execute bit steers control; one-hotness is not checked.
  assign exec = state[PH_EXEC];

  logic unused_phase;
  assign unused_phase = ^{state[PH_FETCH], state[PH_DECODE], state[PH_SLEEP]};

  run_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .exec       (exec),
`ifdef RUN_CTRL_BKPT_EN
    .bkpt_val   (bkpt_val),
    .bkpt_match (bkpt_match),
`endif
    .retired    (retired)
  );

`ifndef RUN_CTRL_BKPT_EN
  assign bkpt_match = 1'b0;
`endif

  assign bkpt_fire = (ctrl_q == CS_RUN) && exec && bkpt_match;

  // Dropping run during execute makes the sequencer fall into sleep at the
  // instruction boundary instead of fetching the next instruction.
  always_comb begin
    ctrl_d = ctrl_q;
    run    = 1'b0;
    unique case (ctrl_q)
      CS_RUN: begin
        run = !bkpt_fire;
        if (bkpt_fire)     ctrl_d = CS_HALTED;
        else if (halt_req) ctrl_d = CS_HALT_PEND;
      end
      CS_HALT_PEND: begin
        run = !exec;
        if (exec) ctrl_d = CS_HALTED;
      end
      CS_HALTED: begin
        // resume wins over a simultaneous step
        if (resume_req)    ctrl_d = CS_RUN;
        else if (step_req) ctrl_d = CS_STEP;
      end
      CS_STEP: begin
        run = !exec;
        if (exec) ctrl_d = CS_HALTED;
      end
      default: ctrl_d = CS_RUN;
    endcase
    halted_d    = (ctrl_d == CS_HALTED);
    step_done_d = (ctrl_q == CS_STEP) && exec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q      <= RST_STATE;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      halted_q    <= halted_d;
      step_done_q <= step_done_d;
    end
  end

  assign halted    = halted_q;
  assign step_done = step_done_q;

`ifdef RUN_CTRL_BKPT_EN
  logic bkpt_hit_q, bkpt_hit_d;

  assign bkpt_hit_d = bkpt_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bkpt_hit_q <= 1'b0;
    else      bkpt_hit_q <= bkpt_hit_d;
  end

  assign bkpt_hit = bkpt_hit_q;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- bench for run_ctrl: a sequencer model driven by run, a
// behavioural reference of the controller, directed scenarios and a
// randomized request/reset soak compared against the reference.
module tb_run_ctrl;

  localparam int W = 16;
`ifdef RUN_CTRL_BKPT_EN
  localparam bit BK = 1'b1;
`else
  localparam bit BK = 1'b0;
`endif

  localparam logic [3:0] S_F = 4'b0001, S_D = 4'b0010, S_E = 4'b0100, S_S = 4'b1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
  logic [3:0]   seq;
  logic         run, halted, step_done;
  logic [W-1:0] retired;
  logic [W-1:0] bkpt_v = '0;
  logic         bkpt_hit;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_ctrl #(.CNT_W(W), .RESET_HALTED(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt_req   (halt_req),
    .resume_req (resume_req),
    .step_req   (step_req),
    .state      (seq),
`ifdef RUN_CTRL_BKPT_EN
    .bkpt_val   (bkpt_v),
    .bkpt_hit   (bkpt_hit),
`endif
    .run        (run),
    .halted     (halted),
    .step_done  (step_done),
    .retired    (retired)
  );

`ifndef RUN_CTRL_BKPT_EN
  assign bkpt_hit = 1'b0;
`endif

  // Sequencer: fetch->decode->execute loop; without run it parks in sleep
  // after execute, and leaves sleep to fetch once run returns.
  function automatic logic [3:0] seq_next(input logic [3:0] s, input logic r);
    if (s == S_F) return S_D;
    if (s == S_D) return S_E;
    if (s == S_E) return r ? S_F : S_S;
    return r ? S_F : S_S;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) seq <= S_F;
    else      seq <= seq_next(seq, run);

  // Reference model of the controller, written from its behavioural rules.
  typedef enum {M_RUN, M_PEND, M_HALTED, M_STEP} mode_t;
  mode_t        m_mode;
  logic [W-1:0] m_ret;
  logic         m_halted, m_sd, m_bh;

  function automatic bit bk_hit(input mode_t m, input logic [3:0] s,
                                input logic [W-1:0] cnt, input logic [W-1:0] bv);
    logic [W-1:0] nxt;
    nxt = cnt + 16'd1;
    return BK && m == M_RUN && s[2] && bv != 0 && nxt == bv;
  endfunction

  function automatic logic exp_run(input mode_t m, input logic [3:0] s,
                                   input logic [W-1:0] cnt, input logic [W-1:0] bv);
    case (m)
      M_RUN:    return !bk_hit(m, s, cnt, bv);
      M_HALTED: return 1'b0;
      default:  return !s[2];
    endcase
  endfunction

  function automatic mode_t mode_next(input mode_t m, input logic [3:0] s,
                                      input logic [W-1:0] cnt, input logic [W-1:0] bv,
                                      input logic h, input logic r, input logic st);
    case (m)
      M_RUN:    return bk_hit(m, s, cnt, bv) ? M_HALTED : (h ? M_PEND : M_RUN);
      M_PEND:   return s[2] ? M_HALTED : M_PEND;
      M_HALTED: return r ? M_RUN : (st ? M_STEP : M_HALTED);
      default:  return s[2] ? M_HALTED : M_STEP;
    endcase
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_mode <= M_RUN; m_ret <= '0; m_halted <= 1'b0; m_sd <= 1'b0; m_bh <= 1'b0;
    end else begin
      m_mode   <= mode_next(m_mode, seq, m_ret, bkpt_v, halt_req, resume_req, step_req);
      m_halted <= mode_next(m_mode, seq, m_ret, bkpt_v, halt_req, resume_req, step_req) == M_HALTED;
      m_sd     <= (m_mode == M_STEP) && seq[2];
      m_bh     <= bk_hit(m_mode, seq, m_ret, bkpt_v);
      m_ret    <= seq[2] ? m_ret + 16'd1 : m_ret;
    end

  task automatic cyc();
    @(negedge clk);
  endtask

  // REQ: reset values, then 9 free-running cycles
  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (run !== 1'b1)      begin errs++; $display("FAIL rst_run got=%b exp=1", run); end
    checks++; if (halted !== 1'b0)   begin errs++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (step_done !== 1'b0) begin errs++; $display("FAIL rst_step_done got=%b exp=0", step_done); end
    checks++; if (retired !== 16'd0) begin errs++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (run !== 1'b1) begin errs++; $display("FAIL free_run c%0d got=%b exp=1", i, run); end
      cyc();
    end
    checks++; if (retired !== 16'd3) begin errs++; $display("FAIL free_retired got=%0d exp=3", retired); end
  endtask

  // REQ: halt_req in decode -> run low in execute, sleep+halted after
  task automatic test_halt();
    cyc();
    checks++; if (seq !== S_D) begin errs++; $display("FAIL halt_setup seq=%b exp=%b", seq, S_D); end
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    checks++; if (run !== 1'b0)      begin errs++; $display("FAIL halt_exec_run got=%b exp=0", run); end
    checks++; if (retired !== 16'd3) begin errs++; $display("FAIL halt_exec_ret got=%0d exp=3", retired); end
    cyc();
    checks++; if (seq !== S_S)       begin errs++; $display("FAIL halt_seq got=%b exp=%b", seq, S_S); end
    checks++; if (halted !== 1'b1)   begin errs++; $display("FAIL halt_halted got=%b exp=1", halted); end
    checks++; if (retired !== 16'd4) begin errs++; $display("FAIL halt_ret got=%0d exp=4", retired); end
    halt_req = 1'b1; cyc(); halt_req = 1'b0; cyc();
    checks++; if (halted !== 1'b1 || run !== 1'b0) begin errs++; $display("FAIL halt_hold halted=%b run=%b exp 1/0", halted, run); end
  endtask

  // REQ: single step from HALTED
  task automatic test_step();
    logic [3:0] es [5] = '{S_S, S_F, S_D, S_E, S_S};
    logic       er [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eh [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    step_req = 1'b1;
    checks++; if (halted !== 1'b1) begin errs++; $display("FAIL step_pre_halted got=%b exp=1", halted); end
    cyc(); step_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seq !== es[k] || run !== er[k] || step_done !== ed[k] || halted !== eh[k]) begin
        errs++;
        $display("FAIL step_c%0d seq=%b run=%b sd=%b halted=%b exp seq=%b run=%b sd=%b halted=%b",
                 k, seq, run, step_done, halted, es[k], er[k], ed[k], eh[k]);
      end
      cyc();
    end
    checks++; if (step_done !== 1'b0) begin errs++; $display("FAIL step_pulse_len got=%b exp=0", step_done); end
    checks++; if (retired !== 16'd5)  begin errs++; $display("FAIL step_ret got=%0d exp=5", retired); end
  endtask

  // REQ: step and resume together -> resume wins
  task automatic test_step_resume();
    int sd_seen = 0;
    step_req = 1'b1; resume_req = 1'b1; cyc(); step_req = 1'b0; resume_req = 1'b0;
    checks++; if (halted !== 1'b0) begin errs++; $display("FAIL sr_halted got=%b exp=0", halted); end
    for (int k = 0; k < 8; k++) begin
      if (step_done) sd_seen++;
      checks++; if (run !== 1'b1) begin errs++; $display("FAIL sr_run c%0d got=%b exp=1", k, run); end
      cyc();
    end
    checks++; if (sd_seen != 0)       begin errs++; $display("FAIL sr_step_done got=%0d pulses exp=0", sd_seen); end
    checks++; if (retired !== 16'd7)  begin errs++; $display("FAIL sr_ret got=%0d exp=7", retired); end
  endtask

  // REQ: reset in second cycle of a step
  task automatic test_reset_mid_step();
    int sd_seen = 0;
    checks++; if (seq !== S_D) begin errs++; $display("FAIL rms_setup seq=%b exp=%b", seq, S_D); end
    halt_req = 1'b1; cyc(); halt_req = 1'b0; cyc();
    checks++; if (halted !== 1'b1) begin errs++; $display("FAIL rms_halted got=%b exp=1", halted); end
    step_req = 1'b1; cyc(); step_req = 1'b0; cyc();
    checks++; if (seq !== S_F) begin errs++; $display("FAIL rms_step2 seq=%b exp=%b", seq, S_F); end
    #2 rst = 1'b0; #1;
    checks++;
    if (halted !== 1'b0 || step_done !== 1'b0 || retired !== 16'd0 || run !== 1'b1) begin
      errs++;
      $display("FAIL rms_async halted=%b sd=%b ret=%0d run=%b exp 0/0/0/1", halted, step_done, retired, run);
    end
    cyc(); rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (step_done) sd_seen++;
      checks++; if (run !== 1'b1) begin errs++; $display("FAIL rms_run c%0d got=%b exp=1", k, run); end
      cyc();
    end
    checks++; if (sd_seen != 0)      begin errs++; $display("FAIL rms_step_done got=%0d pulses exp=0", sd_seen); end
    checks++; if (retired !== 16'd2) begin errs++; $display("FAIL rms_ret got=%0d exp=2", retired); end
  endtask

`ifdef RUN_CTRL_BKPT_EN
  // REQ: breakpoint at retired count 5
  task automatic test_bkpt();
    int hits = 0, zr = 0, n = 0;
    bkpt_v = 16'd5;
    rst = 1'b0; cyc(); rst = 1'b1;
    while (!halted && n < 40) begin
      if (seq[2] && !run) zr++;
      if (bkpt_hit) hits++;
      cyc(); n++;
    end
    checks++; if (!halted)          begin errs++; $display("FAIL bkpt_timeout halted=%b after %0d cycles", halted, n); end
    checks++; if (retired !== 16'd5) begin errs++; $display("FAIL bkpt_ret got=%0d exp=5", retired); end
    checks++; if (zr != 1)          begin errs++; $display("FAIL bkpt_run_low got=%0d exp=1", zr); end
    for (int k = 0; k < 4; k++) begin
      if (bkpt_hit) hits++;
      cyc();
    end
    checks++; if (hits != 1)        begin errs++; $display("FAIL bkpt_hit_pulses got=%0d exp=1", hits); end
    bkpt_v = '0;
    resume_req = 1'b1; cyc(); resume_req = 1'b0;
    checks++; if (halted !== 1'b0)  begin errs++; $display("FAIL bkpt_resume halted=%b exp=0", halted); end
  endtask
`endif

  // Random request/reset soak against the reference model
  task automatic test_random();
    rst = 1'b0; cyc(); rst = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      logic er;
      er = exp_run(m_mode, seq, m_ret, bkpt_v);
      checks++;
      if (run !== er || halted !== m_halted || step_done !== m_sd ||
          retired !== m_ret || bkpt_hit !== (BK ? m_bh : 1'b0)) begin
        errs++;
        $display("FAIL rand_c%0d run=%b halted=%b sd=%b ret=%0d bh=%b exp run=%b halted=%b sd=%b ret=%0d bh=%b",
                 k, run, halted, step_done, retired, bkpt_hit, er, m_halted, m_sd, m_ret, BK ? m_bh : 1'b0);
      end
      halt_req   = ($urandom_range(7) == 0);
      resume_req = ($urandom_range(9) == 0);
      step_req   = ($urandom_range(5) == 0);
      rst        = ($urandom_range(249) != 0);
      if (BK && $urandom_range(99) == 0) bkpt_v = 16'($urandom_range(60));
      cyc();
    end
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_step();
    test_step_resume();
    test_reset_mid_step();
`ifdef RUN_CTRL_BKPT_EN
    test_bkpt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have parameter RESET_HALTED, default 0; 1 means the block halts at the first instruction boundary after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all registers update on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port halt_req  in  1  one-cycle halt request.
REQ-006 SHALL have port resume_req  in  1  one-cycle resume request.
REQ-007 SHALL have port step_req  in  1  one-cycle single-step request.
REQ-008 SHALL have port state  in  4  one-hot sequencer phase; bit0 fetch, bit1 decode, bit2 execute, bit3 sleep.
REQ-009 SHALL have port run  out  1  run enable to the sequencer; combinational (Mealy).
REQ-010 SHALL have port halted  out  1  registered; high while the sequencer is parked in sleep.
REQ-011 SHALL have port step_done  out  1  registered one-cycle pulse on step completion.
REQ-012 SHALL have port retired  out  CNT_W  count of execute cycles.

Function
REQ-013 SHALL implement control states RUN, HALT_PEND, HALTED and STEP.
REQ-014 SHALL drive run: RUN=1; HALT_PEND and STEP = !state[2]; HALTED=0.
- This drops run exactly in the execute cycle, so the sequencer enters sleep at an instruction boundary.
REQ-015 SHALL transition RUN -> HALT_PEND on halt_req; step_req and resume_req are ignored in RUN.
REQ-016 SHALL transition HALT_PEND -> HALTED on the clock edge ending a cycle with state[2]=1.
- halt_req arriving during an execute cycle in RUN completes on the next execute.
REQ-017 SHALL transition HALTED -> RUN on resume_req and HALTED -> STEP on step_req.
- If both arrive in the same cycle, resume wins and no step is performed.
- halt_req in HALTED is ignored.
REQ-018 SHALL transition STEP -> HALTED on the edge ending a cycle with state[2]=1, and assert step_done for exactly the first HALTED cycle.
- halt_req, resume_req and step_req are ignored in STEP.
REQ-019 SHALL complete a step from HALTED in 4 cycles: sleep, fetch, decode, execute; the sequencer is back in sleep on the 5th.
REQ-020 SHALL assert halted when the control state is HALTED; halted deasserts in the cycle after resume_req or step_req is accepted.
REQ-021 SHALL increment retired by 1 on every cycle with state[2]=1, with modulo-2^CNT_W wrap and no saturation.
REQ-022 SHALL decode only state[2] for control; it does not check that state is one-hot.

Reset
REQ-023 SHALL, while rst=0 and independent of clk, set the control state to RUN (HALT_PEND if RESET_HALTED=1), retired=0, halted=0, step_done=0 and bkpt_hit=0.
REQ-024 SHALL abandon any pending halt or step when reset is asserted mid-operation; no step_done is emitted.

Configuration
REQ-025 SHALL, with RUN_CTRL_BKPT_EN defined, add bkpt_val  in  CNT_W and bkpt_hit  out  1 (registered pulse).
- In RUN, when state[2]=1 and retired+1 == bkpt_val (bkpt_val != 0), run SHALL be 0 in that cycle.
- The block SHALL then go to HALTED and pulse bkpt_hit in the first HALTED cycle.
- bkpt_val=0 disables the breakpoint.
REQ-026 SHALL, without RUN_CTRL_BKPT_EN, omit both ports and all breakpoint logic.

Structure
REQ-027 SHALL take the control-state enum and the phase bit indices (PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_SLEEP=3) from shared package run_ctrl_pkg.
REQ-028 SHALL place the retired counter (and the breakpoint compare, when RUN_CTRL_BKPT_EN is defined) in sub-module run_ctrl_cnt.

Verification
REQ-029 SHALL cover: reset release with the sequencer free-running 9 cycles -> run=1 every cycle, retired=3.
REQ-030 SHALL cover: halt_req during decode -> run=0 in the next execute cycle, state=sleep and halted=1 the following cycle, retired incremented by 1.
REQ-031 SHALL cover: step_req while halted -> state sequence sleep, fetch, decode, execute, sleep; run=0 only in the execute cycle; step_done single pulse; retired +1.
REQ-032 SHALL cover: step_req and resume_req in the same HALTED cycle -> RUN, halted=0 next cycle, step_done never asserted.
REQ-033 SHALL cover, with RUN_CTRL_BKPT_EN defined: bkpt_val=5 from reset -> halted after the 5th execute, bkpt_hit single pulse, retired=5.
REQ-034 SHALL cover: rst=0 in the 2nd cycle of a step -> outputs reset immediately with no step_done, then free-run resumes after rst=1.
